// File: rtl/soc_ahb3_sram_loader.sv
// AHB3-Lite write master: streams valid/ready words into consecutive word addresses
// as pipelined INCR writes, with wait-state and ERROR handling and a job handshake.
module soc_ahb3_sram_loader #(
    parameter int PLEN = 16,
    parameter int XLEN = 32,
    parameter int LW   = 16
) (
    input  logic            ahb3_clk_i,
    input  logic            ahb3_rst_i,
    input  logic            start_i,
    input  logic [PLEN-1:0] start_addr_i,
    input  logic [LW-1:0]   length_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    input  logic [XLEN-1:0] s_data_i,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    output logic            ahb3_hsel_o,
    output logic [PLEN-1:0] ahb3_haddr_o,
    output logic [XLEN-1:0] ahb3_hwdata_o,
    output logic            ahb3_hwrite_o,
    output logic [2:0]      ahb3_hsize_o,
    output logic [2:0]      ahb3_hburst_o,
    output logic [3:0]      ahb3_hprot_o,
    output logic [1:0]      ahb3_htrans_o,
    output logic            ahb3_hmastlock_o,
    input  logic            ahb3_hready_i,
    input  logic            ahb3_hresp_i
);
    localparam int SW      = XLEN / 8;
    localparam int BYTE_AW = $clog2(SW);
    localparam int KB_W    = (PLEN < 10) ? PLEN : 10;
    localparam logic [PLEN-1:0] ALIGN_MASK = ~PLEN'(SW - 1);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_ERR,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [PLEN-1:0] addr_reg;
    logic [LW-1:0]   remain_reg;
    logic [PLEN-1:0] haddr_reg;
    logic [1:0]      htrans_reg;
    logic [XLEN-1:0] hwdata_reg;
    logic [XLEN-1:0] pend_reg;
    logic            dphase_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            error_reg;

    logic addr_free;
    logic err_resp;
    logic data_done;
    logic kb_boundary;
    logic s_ready;
    logic accept;

    assign addr_free   = (htrans_reg == HTRANS_IDLE) || ahb3_hready_i;
    assign err_resp    = dphase_reg && ahb3_hresp_i && !ahb3_hready_i;
    assign data_done   = dphase_reg && ahb3_hready_i && !ahb3_hresp_i;
    assign kb_boundary = (addr_reg[KB_W-1:0] == '0);
    assign s_ready     = (state_reg == ST_RUN) && (remain_reg != '0) && addr_free && !err_resp;
    assign accept      = s_ready && s_valid_i;

    always_ff @(posedge ahb3_clk_i) begin
        if (ahb3_rst_i) begin
            state_reg  <= ST_IDLE;
            addr_reg   <= '0;
            remain_reg <= '0;
            haddr_reg  <= '0;
            htrans_reg <= HTRANS_IDLE;
            hwdata_reg <= '0;
            pend_reg   <= '0;
            dphase_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            if (ahb3_hready_i) begin
                dphase_reg <= (htrans_reg != HTRANS_IDLE);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_reg   <= start_addr_i & ALIGN_MASK;
                        remain_reg <= length_i;
                        error_reg  <= 1'b0;
                        busy_reg   <= 1'b1;
                        // An empty job has nothing outstanding, so the drain check ends it at once.
                        state_reg  <= (length_i != '0) ? ST_RUN : ST_DRAIN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (err_resp) begin
                        htrans_reg <= HTRANS_IDLE;
                        state_reg  <= ST_ERR;
                    end else begin
                        if (ahb3_hready_i && (htrans_reg != HTRANS_IDLE)) begin
                            hwdata_reg <= pend_reg;
                        end
                        if (accept) begin
                            haddr_reg  <= addr_reg;
                            // Continue a burst only back-to-back and never across a 1 KB line.
                            htrans_reg <= ((htrans_reg != HTRANS_IDLE) && !kb_boundary) ?
                                          HTRANS_SEQ : HTRANS_NONSEQ;
                            pend_reg   <= s_data_i;
                            addr_reg   <= addr_reg + PLEN'(SW);
                            remain_reg <= remain_reg - LW'(1);
                            if (remain_reg == LW'(1)) begin
                                state_reg <= ST_DRAIN;
                            end
                        end else if (addr_free) begin
                            htrans_reg <= HTRANS_IDLE;
                        end
                        if ((state_reg == ST_DRAIN) && (htrans_reg == HTRANS_IDLE) &&
                            (!dphase_reg || data_done)) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                ST_ERR: begin
                    if (ahb3_hready_i) begin
                        error_reg <= 1'b1;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o           = busy_reg;
    assign done_o           = done_reg;
    assign error_o          = error_reg;
    assign s_ready_o        = s_ready;
    assign ahb3_hsel_o      = (htrans_reg != HTRANS_IDLE);
    assign ahb3_haddr_o     = haddr_reg;
    assign ahb3_hwdata_o    = hwdata_reg;
    assign ahb3_htrans_o    = htrans_reg;
    assign ahb3_hwrite_o    = 1'b1;
    assign ahb3_hsize_o     = 3'(BYTE_AW);
    assign ahb3_hburst_o    = 3'b001;
    assign ahb3_hprot_o     = 4'b0011;
    assign ahb3_hmastlock_o = 1'b0;
endmodule

// File: tb/tb_soc_ahb3_sram_loader.sv
// Directed bench for soc_ahb3_sram_loader: an AHB SRAM slave model with stall/error
// injection and address/data scoreboards fed by each job's expected beats.
module tb_soc_ahb3_sram_loader;
    localparam int PLEN = 16;
    localparam int XLEN = 32;
    localparam int LW   = 16;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic [PLEN-1:0] start_addr_i = '0;
    logic [LW-1:0]   length_i = '0;
    logic            busy_o, done_o, error_o;
    logic [XLEN-1:0] s_data_i = '0;
    logic            s_valid_i = 1'b1;
    logic            s_ready_o;
    logic            hsel, hwrite, hmastlock;
    logic [PLEN-1:0] haddr;
    logic [XLEN-1:0] hwdata;
    logic [2:0]      hsize, hburst;
    logic [3:0]      hprot;
    logic [1:0]      htrans;
    logic            hready = 1'b1;
    logic            hresp = 1'b0;

    soc_ahb3_sram_loader #(.PLEN(PLEN), .XLEN(XLEN), .LW(LW)) dut (
        .ahb3_clk_i(clk), .ahb3_rst_i(rst),
        .start_i(start_i), .start_addr_i(start_addr_i), .length_i(length_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .ahb3_hsel_o(hsel), .ahb3_haddr_o(haddr), .ahb3_hwdata_o(hwdata),
        .ahb3_hwrite_o(hwrite), .ahb3_hsize_o(hsize), .ahb3_hburst_o(hburst),
        .ahb3_hprot_o(hprot), .ahb3_htrans_o(htrans), .ahb3_hmastlock_o(hmastlock),
        .ahb3_hready_i(hready), .ahb3_hresp_i(hresp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PLEN-1:0] addr;
        logic [1:0]      trans;
    } aph_t;

    aph_t            exp_aph_q[$];
    logic [XLEN-1:0] exp_data_q[$];
    logic [XLEN-1:0] mem [0:16383];
    logic [XLEN-1:0] words [0:63];
    int              stream_idx = 0;
    int              valid_mode = 0;
    int              n_cmp = 0;
    int              n_bad = 0;
    int              cyc = 0;
    int              done_cnt = 0;
    int              done_cyc = 0;
    logic            done_busy = 1'b0;
    logic            done_err = 1'b0;
    int              n_err_resp = 0;
    logic            dphase_tb = 1'b0;
    logic [PLEN-1:0] daddr_tb = '0;
    logic [PLEN-1:0] stall_addr = '0;
    int              stall_left = 0;
    logic [PLEN-1:0] err_addr = '0;
    logic            err_armed = 1'b0;
    logic            err_phase = 1'b0;
    logic            hold_valid = 1'b0;
    logic [XLEN-1:0] hold_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [PLEN-1:0] addr, input logic [1:0] trans, input int widx);
        aph_t e;
        e.addr  = addr;
        e.trans = trans;
        exp_aph_q.push_back(e);
        exp_data_q.push_back(words[widx % 64]);
    endtask

    // Bus observation at the falling edge: data phase first, then address phase.
    task automatic monitor();
        aph_t e;
        cyc++;
        if (rst) return;
        if (done_o) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy_o;
            done_err  = error_o;
        end
        check("hsel", hsel, htrans != T_IDLE);
        if (dphase_tb && hready) begin
            if (hresp) begin
                n_err_resp++;
            end else begin
                check("data_queued", exp_data_q.size() != 0, 1);
                if (exp_data_q.size() != 0) check("hwdata", hwdata, exp_data_q.pop_front());
                mem[daddr_tb[15:2]] = hwdata;
            end
        end
        if (hready && hresp) check("err_idle", htrans, T_IDLE);
        if (!hready && !hresp && htrans != T_IDLE) begin
            check("s_ready_stall", s_ready_o, 0);
            check("haddr_stall", haddr, stall_addr);
            if (hold_valid) check("hwdata_hold", hwdata, hold_val);
            else begin
                hold_val   = hwdata;
                hold_valid = 1'b1;
            end
        end else if (hready) begin
            hold_valid = 1'b0;
        end
        if (hready) begin
            dphase_tb = (htrans != T_IDLE);
            if (htrans != T_IDLE) begin
                daddr_tb = haddr;
                check("aph_queued", exp_aph_q.size() != 0, 1);
                if (exp_aph_q.size() != 0) begin
                    e = exp_aph_q.pop_front();
                    check("haddr", haddr, e.addr);
                    check("htrans", htrans, e.trans);
                end
            end
        end
    endtask

    // One clock: observe, then drive stream and slave response for the next cycle.
    task automatic tick();
        logic acc;
        @(negedge clk);
        monitor();
        acc = s_valid_i && s_ready_o;
        @(posedge clk);
        #1;
        if (acc) stream_idx++;
        s_data_i = words[stream_idx % 64];
        if (valid_mode == 1) s_valid_i = ~s_valid_i;
        hresp  = 1'b0;
        hready = 1'b1;
        if (err_armed && dphase_tb && daddr_tb == err_addr) begin
            hresp = 1'b1;
            if (!err_phase) begin
                hready    = 1'b0;
                err_phase = 1'b1;
            end else begin
                err_armed = 1'b0;
                err_phase = 1'b0;
            end
        end else if (stall_left > 0 && htrans != T_IDLE && haddr == stall_addr) begin
            hready = 1'b0;
            stall_left--;
        end
    endtask

    task automatic run_job(input logic [PLEN-1:0] base, input int len, input int exp_lat, input bit poke);
        int s, d0, k;
        d0 = done_cnt;
        start_addr_i = base;
        length_i     = LW'(len);
        start_i      = 1'b1;
        tick();
        s       = cyc;
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("error_cleared", error_o, 0);
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            if (poke && k == 1) begin
                start_i      = 1'b1;
                start_addr_i = 16'h7000;
                length_i     = 16'd1;
            end else begin
                start_i = 1'b0;
            end
            tick();
            k++;
        end
        start_i = 1'b0;
        check("done_seen", done_cnt - d0, 1);
        if (exp_lat >= 0) check("latency", done_cyc - s, exp_lat);
        check("busy_at_done", done_busy, 0);
        check("done_one_cycle", done_o, 0);
        $display("job base=%04h len=%0d latency=%0d error=%0d", base, len, done_cyc - s, done_err);
    endtask

    task automatic check_drained();
        repeat (3) tick();
        check("aph_left", exp_aph_q.size(), 0);
        check("data_left", exp_data_q.size(), 0);
    endtask

    initial begin
        int b;
        for (int i = 0; i < 64; i++) words[i] = 32'h5A00_0000 + 32'h0001_0203 * (i + 1);
        s_data_i = words[0];
        repeat (3) tick();
        check("rst_htrans", htrans, T_IDLE);
        check("rst_hsel", hsel, 0);
        check("rst_flags", {busy_o, done_o, error_o, s_ready_o}, 4'b0000);
        check("const_ctrl", {hwrite, hsize, hburst, hprot, hmastlock}, {1'b1, 3'd2, 3'd1, 4'b0011, 1'b0});
        rst = 1'b0;
        tick();

        // Basic burst, with a start pulse mid-job that must be ignored.
        b = stream_idx;
        push_beat(16'h0100, T_NSEQ, b);
        push_beat(16'h0104, T_SEQ, b + 1);
        push_beat(16'h0108, T_SEQ, b + 2);
        push_beat(16'h010C, T_SEQ, b + 3);
        run_job(16'h0100, 4, 7, 1'b1);
        check_drained();
        check("stream_consumed", stream_idx - b, 4);
        for (int i = 0; i < 4; i++) check("sram_readback", mem[16'h0040 + i], words[(b + i) % 64]);

        // Two wait states on the address phase of beat 2.
        b = stream_idx;
        stall_addr = 16'h0108;
        stall_left = 2;
        push_beat(16'h0100, T_NSEQ, b);
        push_beat(16'h0104, T_SEQ, b + 1);
        push_beat(16'h0108, T_SEQ, b + 2);
        push_beat(16'h010C, T_SEQ, b + 3);
        run_job(16'h0100, 4, 9, 1'b0);
        check_drained();
        check("stall_hwdata", hold_val, words[(b + 1) % 64]);

        // Gapped stream: every beat restarts with NONSEQ.
        b = stream_idx;
        valid_mode = 1;
        s_valid_i  = 1'b0;
        push_beat(16'h0300, T_NSEQ, b);
        push_beat(16'h0304, T_NSEQ, b + 1);
        push_beat(16'h0308, T_NSEQ, b + 2);
        run_job(16'h0300, 3, 8, 1'b0);
        valid_mode = 0;
        s_valid_i  = 1'b1;
        check_drained();

        // 1 KB boundary with unaligned base, then wrap of the address space.
        b = stream_idx;
        push_beat(16'h03F8, T_NSEQ, b);
        push_beat(16'h03FC, T_SEQ, b + 1);
        push_beat(16'h0400, T_NSEQ, b + 2);
        push_beat(16'h0404, T_SEQ, b + 3);
        run_job(16'h03FA, 4, 7, 1'b0);
        check_drained();
        b = stream_idx;
        push_beat(16'hFFF8, T_NSEQ, b);
        push_beat(16'hFFFC, T_SEQ, b + 1);
        push_beat(16'h0000, T_NSEQ, b + 2);
        run_job(16'hFFF8, 3, 6, 1'b0);
        check_drained();

        // ERROR response on the data phase of beat 2.
        b = stream_idx;
        err_addr  = 16'h0508;
        err_armed = 1'b1;
        n_err_resp = 0;
        exp_aph_q.push_back('{addr: 16'h0500, trans: T_NSEQ});
        exp_aph_q.push_back('{addr: 16'h0504, trans: T_SEQ});
        exp_aph_q.push_back('{addr: 16'h0508, trans: T_SEQ});
        exp_data_q.push_back(words[b % 64]);
        exp_data_q.push_back(words[(b + 1) % 64]);
        run_job(16'h0500, 6, 7, 1'b0);
        check("error_with_done", done_err, 1);
        check_drained();
        check("error_sticky", error_o, 1);
        check("error_responses", n_err_resp, 1);

        // Empty job clears the error and touches no bus.
        run_job(16'h0600, 0, 2, 1'b0);
        check_drained();

        // Reset in the middle of a job.
        b = stream_idx;
        push_beat(16'h0800, T_NSEQ, b);
        for (int i = 1; i < 8; i++) push_beat(16'(16'h0800 + 4 * i), T_SEQ, b + i);
        start_addr_i = 16'h0800;
        length_i     = 16'd8;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_htrans", htrans, T_IDLE);
        check("mid_rst_hsel", hsel, 0);
        check("mid_rst_haddr", haddr, 0);
        check("mid_rst_hwdata", hwdata, 0);
        check("mid_rst_flags", {busy_o, done_o, error_o, s_ready_o}, 4'b0000);
        rst = 1'b0;
        exp_aph_q.delete();
        exp_data_q.delete();
        dphase_tb  = 1'b0;
        hold_valid = 1'b0;
        repeat (2) tick();
        check("post_rst_idle", {htrans, busy_o}, 3'b000);

        // Recovery job after reset.
        b = stream_idx;
        push_beat(16'h0040, T_NSEQ, b);
        push_beat(16'h0044, T_SEQ, b + 1);
        run_job(16'h0040, 2, 5, 1'b0);
        check_drained();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
